peripheral_biu_arbiter: RTL and testbench
=========================================

// Module: peripheral_biu_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one downstream simple memory port (req/we/addr/be/data)
//  between NUM_MASTERS requesters. One transaction outstanding at a time; a response timeout
//  frees the port if the target never responds. Sits in front of the BIU memory-side port.
// PARAMETERS
//  NUM_MASTERS     4    number of requesters, 2..8
//  AXI_ADDR_WIDTH  64   address width
//  AXI_DATA_WIDTH  64   data width; byte enables are AXI_DATA_WIDTH/8
//  TIMEOUT         256  cycles to wait for rvalid_i in RSP; 0 = timeout disabled
// PORTS
//  clk_i        in   1       clock; all logic on posedge
//  rst_i        in   1       asynchronous reset, active-high
//  m_req_i      in   N       per-master request
//  m_we_i       in   N       per-master write enable (1 = write)
//  m_addr_i     in   N*AW    per-master address, master k at [k*AW +: AW]
//  m_be_i       in   N*DW/8  per-master byte enables
//  m_wdata_i    in   N*DW    per-master write data
//  m_gnt_o      out  N       one-cycle pulse: master's request accepted downstream
//  m_rvalid_o   out  N       one-cycle pulse: response (read or write) for that master
//  m_err_o      out  N       qualifies m_rvalid_o: 1 = timed out
//  m_rdata_o    out  DW      read data, shared, valid with m_rvalid_o
//  busy_o       out  1       state != IDLE
//  req_o        out  1       downstream request, registered
//  we_o         out  1       downstream write enable, registered
//  addr_o       out  AW      downstream address, registered
//  be_o         out  DW/8    downstream byte enables, registered
//  data_o       out  DW      downstream write data, registered
//  gnt_i        in   1       downstream accepts request while req_o=1
//  rvalid_i     in   1       downstream response valid (reads and writes)
//  data_i       in   DW      downstream read data, valid with rvalid_i
// BEHAVIOUR
//  Reset: state IDLE; req_o, we_o, addr_o, be_o, data_o = 0; m_gnt_o/m_rvalid_o/m_err_o = 0;
//   m_rdata_o = 0; rr pointer last = N-1, so master 0 has highest priority; timeout counter 0.
//   Reset mid-transaction abandons it: no m_gnt_o/m_rvalid_o is produced for it.
//  FSM IDLE -> REQ -> RSP -> IDLE.
//  IDLE: if any m_req_i, winner = first requester scanning last+1, last+2, ... (mod N).
//   Capture winner's we/addr/be/wdata into the output registers; req_o=1 from next edge; last := winner;
//   enter REQ. No request: stay in IDLE, req_o=0.
//  REQ: req_o and all fields held stable until gnt_i=1. In the gnt_i=1 cycle,
//   m_gnt_o[idx] = 1 (combinational from gnt_i). Next edge: req_o=0, enter RSP, counter cleared.
//  RSP: m_rvalid_o[idx] = rvalid_i, m_rdata_o = data_i (combinational), m_err_o=0; on rvalid_i -> IDLE.
//   When TIMEOUT!=0, the counter increments each RSP cycle without rvalid_i. On the TIMEOUT-th such
//   cycle, m_rvalid_o[idx]=1 and m_err_o[idx]=1, m_rdata_o=0; -> IDLE. rvalid_i in that cycle wins (no error).
//  rvalid_i/gnt_i outside RSP/REQ respectively: ignored; late responses after timeout are dropped.
//  Latency: m_req_i rising in IDLE -> req_o at +1 cycle; with gnt_i tied 1, m_gnt_o at +1.
//   After rvalid_i, the next arbitration occurs in the following (IDLE) cycle.
//  Requester contract: hold m_req_i and fields until m_gnt_o. Fields are sampled only at
//   arbitration; a request withdrawn after capture is still issued and completes.
//  Only the granted index's m_gnt_o/m_rvalid_o/m_err_o bits can be nonzero; at most one bit per cycle.
//  Counter width $clog2(TIMEOUT+1); it saturates, so no wrap.
// TESTING
//  1 m0 write addr 0x1000 data 0xDEADBEEF be 0xFF, gnt_i=1, rvalid_i 2 cyc later -> req_o @+1,
//    we_o=1, m_gnt_o=0001 @+1, m_rvalid_o=0001 m_err_o=0 @+3, busy_o low afterwards.
//  2 m0..m3 requesting continuously, immediate gnt/rvalid -> grant order 0,1,2,3,0,1; m2 alone
//    after last=3 -> m2 granted next.
//  3 m1 read addr 0x20, rvalid_i with data_i=0x0123456789ABCDEF -> m_rvalid_o=0010,
//    m_rdata_o=0x0123456789ABCDEF.
//  4 gnt_i low 5 cycles -> req_o/addr_o/data_o stable all 5 cycles, m_gnt_o=0 until gnt_i=1.
//  5 TIMEOUT=8, no rvalid_i -> m_rvalid_o[idx]=m_err_o[idx]=1 on the 8th RSP cycle, IDLE next;
//    rvalid_i 3 cyc later ignored, no pulse.
//  6 rst_i pulsed while in RSP -> req_o=0, busy_o=0 immediately (async); after release, m0 and m3
//    both requesting -> m0 granted first.

Source files
------------

// File: rtl/peripheral_biu_arbiter.sv
// Round-robin sequencer that shares one downstream memory port among NUM_MASTERS requesters.
// Only one transaction is in flight at a time, and a response timeout recovers a port that never answers.
module peripheral_biu_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int TIMEOUT        = 256
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NUM_MASTERS-1:0]                     m_req_i,
    input  logic [NUM_MASTERS-1:0]                     m_we_i,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]      m_addr_i,
    input  logic [NUM_MASTERS*(AXI_DATA_WIDTH/8)-1:0]  m_be_i,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]      m_wdata_i,
    output logic [NUM_MASTERS-1:0]                     m_gnt_o,
    output logic [NUM_MASTERS-1:0]                     m_rvalid_o,
    output logic [NUM_MASTERS-1:0]                     m_err_o,
    output logic [AXI_DATA_WIDTH-1:0]                  m_rdata_o,
    output logic                                       busy_o,
    output logic                                       req_o,
    output logic                                       we_o,
    output logic [AXI_ADDR_WIDTH-1:0]                  addr_o,
    output logic [AXI_DATA_WIDTH/8-1:0]                be_o,
    output logic [AXI_DATA_WIDTH-1:0]                  data_o,
    input  logic                                       gnt_i,
    input  logic                                       rvalid_i,
    input  logic [AXI_DATA_WIDTH-1:0]                  data_i
);

    localparam int BW      = AXI_DATA_WIDTH / 8;
    localparam int IW      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } state_e;

    state_e                    state_q, state_d;
    logic [IW-1:0]             last_q, last_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BW-1:0]             be_q, be_d;
    logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic                      found;
    logic [IW-1:0]             winnerIdx;
    logic                      timeoutHit;

    // Scan starts one past the last winner, so the previous winner has the lowest priority.
    always_comb begin
        found     = 1'b0;
        winnerIdx = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            if (!found && m_req_i[(int'(last_q) + off) % NUM_MASTERS]) begin
                found     = 1'b1;
                winnerIdx = IW'((int'(last_q) + off) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        idx_d      = idx_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        timeoutHit = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = m_we_i[winnerIdx];
                    addr_d  = m_addr_i[int'(winnerIdx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    be_d    = m_be_i[int'(winnerIdx)*BW +: BW];
                    data_d  = m_wdata_i[int'(winnerIdx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                    last_d  = winnerIdx;
                    idx_d   = winnerIdx;
                end
            end
            REQ: begin
                if (gnt_i) begin
                    state_d = RSP;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            RSP: begin
                if (rvalid_i) begin
                    state_d = IDLE;
                end else if (TIMEOUT != 0) begin
                    // A response arriving in the final cycle takes precedence over the timeout.
                    if (cnt_q == CW'(TO_LAST)) begin
                        timeoutHit = 1'b1;
                        state_d    = IDLE;
                    end else if (cnt_q < CW'(TO_LAST)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        if (state_q == REQ && gnt_i) begin
            m_gnt_o[idx_q] = 1'b1;
        end
        if (state_q == RSP) begin
            m_rdata_o = timeoutHit ? '0 : data_i;
            if (rvalid_i || timeoutHit) begin
                m_rvalid_o[idx_q] = 1'b1;
            end
            if (timeoutHit) begin
                m_err_o[idx_q] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_MASTERS - 1);
            idx_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign req_o  = req_q;
    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign be_o   = be_q;
    assign data_o = data_q;

endmodule

// File: tb/tb_peripheral_biu_arbiter.sv
// Directed testbench for peripheral_biu_arbiter with four masters and TIMEOUT set to 8.
// Each comparison is an immediate assertion that checks against a hand-computed value.
module tb_peripheral_biu_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      m_req_i;
    logic [N-1:0]      m_we_i;
    logic [N*AW-1:0]   m_addr_i;
    logic [N*BW-1:0]   m_be_i;
    logic [N*DW-1:0]   m_wdata_i;
    logic [N-1:0]      m_gnt_o;
    logic [N-1:0]      m_rvalid_o;
    logic [N-1:0]      m_err_o;
    logic [DW-1:0]     m_rdata_o;
    logic              busy_o;
    logic              req_o;
    logic              we_o;
    logic [AW-1:0]     addr_o;
    logic [BW-1:0]     be_o;
    logic [DW-1:0]     data_o;
    logic              gnt_i;
    logic              rvalid_i;
    logic [DW-1:0]     data_i;

    int compared   = 0;
    int mismatched = 0;

    peripheral_biu_arbiter #(
        .NUM_MASTERS    (N),
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .TIMEOUT        (TO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_be_i     (m_be_i),
        .m_wdata_i  (m_wdata_i),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_err_o    (m_err_o),
        .m_rdata_o  (m_rdata_o),
        .busy_o     (busy_o),
        .req_o      (req_o),
        .we_o       (we_o),
        .addr_o     (addr_o),
        .be_o       (be_o),
        .data_o     (data_o),
        .gnt_i      (gnt_i),
        .rvalid_i   (rvalid_i),
        .data_i     (data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input logic we, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] be);
        m_we_i[k]              = we;
        m_addr_i[k*AW +: AW]   = addr;
        m_wdata_i[k*DW +: DW]  = wdata;
        m_be_i[k*BW +: BW]     = be;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i     = 1'b1;
        m_req_i   = '0;
        m_we_i    = '0;
        m_addr_i  = '0;
        m_be_i    = '0;
        m_wdata_i = '0;
        gnt_i     = 1'b0;
        rvalid_i  = 1'b0;
        data_i    = '0;
        #2;
        checkOutput("reset req_o", 64'(req_o), 64'h0);
        checkOutput("reset busy_o", 64'(busy_o), 64'h0);
        checkOutput("reset addr_o", addr_o, 64'h0);
        checkOutput("reset m_gnt_o", 64'(m_gnt_o), 64'h0);
        checkOutput("reset m_rvalid_o", 64'(m_rvalid_o), 64'h0);
        checkOutput("reset m_rdata_o", m_rdata_o, 64'h0);
        tick();
        rst_i = 1'b0;

        // Round-robin order starting from last = 3, then a lone requester.
        gnt_i    = 1'b1;
        rvalid_i = 1'b1;
        for (int k = 0; k < N; k++) applyStimulus(k, 1'b1, 64'(k * 256), 64'(k + 1), 8'hFF);
        m_req_i = 4'hF;
        for (int g = 0; g < 8; g++) begin
            tick();
            checkOutput($sformatf("rr gnt #%0d", g), 64'(m_gnt_o), 64'(4'b0001 << (g % 4)));
            checkOutput($sformatf("rr addr #%0d", g), addr_o, 64'((g % 4) * 256));
            tick();
            checkOutput($sformatf("rr rvalid #%0d", g), 64'(m_rvalid_o), 64'(4'b0001 << (g % 4)));
            tick();
        end
        m_req_i = 4'b0100;
        tick();
        checkOutput("m2 alone gnt", 64'(m_gnt_o), 64'h4);
        m_req_i = '0;
        tick();
        checkOutput("m2 alone rvalid", 64'(m_rvalid_o), 64'h4);
        tick();
        rvalid_i = 1'b0;

        // Single write from m0.
        applyStimulus(0, 1'b1, 64'h1000, 64'hDEADBEEF, 8'hFF);
        m_req_i = 4'b0001;
        settle();
        checkOutput("wr idle busy_o", 64'(busy_o), 64'h0);
        checkOutput("wr idle req_o", 64'(req_o), 64'h0);
        tick();
        checkOutput("wr req_o", 64'(req_o), 64'h1);
        checkOutput("wr we_o", 64'(we_o), 64'h1);
        checkOutput("wr addr_o", addr_o, 64'h1000);
        checkOutput("wr data_o", data_o, 64'hDEADBEEF);
        checkOutput("wr be_o", 64'(be_o), 64'hFF);
        checkOutput("wr m_gnt_o", 64'(m_gnt_o), 64'h1);
        m_req_i = '0;
        tick();
        checkOutput("wr rsp wait rvalid", 64'(m_rvalid_o), 64'h0);
        checkOutput("wr rsp req_o", 64'(req_o), 64'h0);
        checkOutput("wr rsp busy_o", 64'(busy_o), 64'h1);
        tick();
        rvalid_i = 1'b1;
        settle();
        checkOutput("wr m_rvalid_o", 64'(m_rvalid_o), 64'h1);
        checkOutput("wr m_err_o", 64'(m_err_o), 64'h0);
        tick();
        rvalid_i = 1'b0;
        settle();
        checkOutput("wr done busy_o", 64'(busy_o), 64'h0);

        // Read from m1 with returned data.
        applyStimulus(1, 1'b0, 64'h20, 64'h0, 8'h0F);
        m_req_i = 4'b0010;
        tick();
        checkOutput("rd we_o", 64'(we_o), 64'h0);
        checkOutput("rd addr_o", addr_o, 64'h20);
        checkOutput("rd m_gnt_o", 64'(m_gnt_o), 64'h2);
        m_req_i = '0;
        tick();
        rvalid_i = 1'b1;
        data_i   = 64'h0123456789ABCDEF;
        settle();
        checkOutput("rd m_rvalid_o", 64'(m_rvalid_o), 64'h2);
        checkOutput("rd m_rdata_o", m_rdata_o, 64'h0123456789ABCDEF);
        tick();
        rvalid_i = 1'b0;
        data_i   = '0;

        // Downstream stalls the grant for five cycles.
        applyStimulus(3, 1'b1, 64'h3000, 64'h55AA55AA, 8'h0F);
        gnt_i   = 1'b0;
        m_req_i = 4'b1000;
        tick();
        for (int i = 0; i < 5; i++) begin
            settle();
            checkOutput($sformatf("stall req_o c%0d", i), 64'(req_o), 64'h1);
            checkOutput($sformatf("stall addr_o c%0d", i), addr_o, 64'h3000);
            checkOutput($sformatf("stall data_o c%0d", i), data_o, 64'h55AA55AA);
            checkOutput($sformatf("stall m_gnt_o c%0d", i), 64'(m_gnt_o), 64'h0);
            tick();
        end
        gnt_i = 1'b1;
        settle();
        checkOutput("stall release m_gnt_o", 64'(m_gnt_o), 64'h8);
        m_req_i = '0;
        tick();
        rvalid_i = 1'b1;
        settle();
        checkOutput("stall m_rvalid_o", 64'(m_rvalid_o), 64'h8);
        tick();
        rvalid_i = 1'b0;

        // Response timeout on m0, then a late response that must be dropped.
        applyStimulus(0, 1'b0, 64'h4000, 64'h0, 8'hFF);
        data_i  = 64'hFFFF0000FFFF0000;
        m_req_i = 4'b0001;
        tick();
        checkOutput("to m_gnt_o", 64'(m_gnt_o), 64'h1);
        m_req_i = '0;
        tick();
        for (int j = 1; j < TO; j++) begin
            settle();
            checkOutput($sformatf("to early rvalid c%0d", j), 64'(m_rvalid_o), 64'h0);
            checkOutput($sformatf("to early err c%0d", j), 64'(m_err_o), 64'h0);
            tick();
        end
        settle();
        checkOutput("to m_rvalid_o", 64'(m_rvalid_o), 64'h1);
        checkOutput("to m_err_o", 64'(m_err_o), 64'h1);
        checkOutput("to m_rdata_o", m_rdata_o, 64'h0);
        tick();
        checkOutput("to idle busy_o", 64'(busy_o), 64'h0);
        tick();
        tick();
        rvalid_i = 1'b1;
        settle();
        checkOutput("late rvalid dropped", 64'(m_rvalid_o), 64'h0);
        checkOutput("late err dropped", 64'(m_err_o), 64'h0);
        tick();
        rvalid_i = 1'b0;
        data_i   = '0;

        // Asynchronous reset during RSP, then priority restarts at m0.
        applyStimulus(1, 1'b1, 64'h5000, 64'h1111, 8'hFF);
        m_req_i = 4'b0010;
        tick();
        checkOutput("rst pre m_gnt_o", 64'(m_gnt_o), 64'h2);
        m_req_i = '0;
        tick();
        checkOutput("rst pre busy_o", 64'(busy_o), 64'h1);
        rst_i    = 1'b1;
        rvalid_i = 1'b1;
        settle();
        checkOutput("rst async busy_o", 64'(busy_o), 64'h0);
        checkOutput("rst async req_o", 64'(req_o), 64'h0);
        checkOutput("rst async addr_o", addr_o, 64'h0);
        checkOutput("rst dropped rvalid", 64'(m_rvalid_o), 64'h0);
        tick();
        rst_i    = 1'b0;
        rvalid_i = 1'b0;
        applyStimulus(0, 1'b0, 64'h6000, 64'h0, 8'hFF);
        applyStimulus(3, 1'b0, 64'h7000, 64'h0, 8'hFF);
        m_req_i = 4'b1001;
        tick();
        checkOutput("post rst first gnt", 64'(m_gnt_o), 64'h1);
        checkOutput("post rst addr_o", addr_o, 64'h6000);
        m_req_i = 4'b1000;
        tick();
        rvalid_i = 1'b1;
        settle();
        checkOutput("post rst m0 rvalid", 64'(m_rvalid_o), 64'h1);
        tick();
        rvalid_i = 1'b0;
        tick();
        checkOutput("post rst second gnt", 64'(m_gnt_o), 64'h8);
        checkOutput("post rst m3 addr_o", addr_o, 64'h7000);
        m_req_i = '0;
        tick();
        rvalid_i = 1'b1;
        settle();
        checkOutput("post rst m3 rvalid", 64'(m_rvalid_o), 64'h8);
        tick();
        rvalid_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
